control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/dec3to8.sv | 12 +
 rtl/control_unit.sv | 127 ++++++++++++
 tb/tb_control_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the simple CPU control path: opcodes, FSM steps, IR fields.
// Latency: n/a (package only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int OPC_W = 3;
    localparam int REG_W = 3;
    localparam int IR_W  = OPC_W + 2 * REG_W;

    localparam logic [OPC_W-1:0] OP_MV   = 3'b000;
    localparam logic [OPC_W-1:0] OP_MVI  = 3'b001;
    localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OPC_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OPC_W-1:0] OP_MVNZ = 3'b100;

    // One state per instruction step; T0 is fetch/idle.
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable, used for the register write strobes.
// Latency: combinational.
// Backpressure: none.
module dec3to8 (
    input  logic [2:0] i_sel,
    input  logic       i_en,
    output logic [7:0] o_onehot
);

    assign o_onehot = i_en ? (8'b0000_0001 << i_sel) : 8'b0;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for mv/mvi/add/sub (+ mvnz when CTRL_MVNZ_EN is defined).
// Latency: mv/mvi/undefined 2 cycles, add/sub 4 cycles; outputs combinational from state and IR.
// Backpressure: Run is only sampled in T0; while an instruction executes Run is ignored.
module control_unit
    import cpu_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Run,
    input  logic [N-1:0] DIN,
    input  logic         Gnz,
    output logic [7:0]   selectR,
    output logic         selectG,
    output logic         selectDin,
    output logic [7:0]   Rin,
    output logic         Ain,
    output logic         Gin,
    output logic         AddSub,
    output logic         IRin,
    output logic         Done
);

    state_t            r_state;
    logic [IR_W-1:0]   r_ir;

    logic [OPC_W-1:0]  w_op;
    logic [REG_W-1:0]  w_x;
    logic [REG_W-1:0]  w_y;
    logic              w_rin_en;
    logic              w_unused;

    assign w_op = r_ir[8:6];
    assign w_x  = r_ir[5:3];
    assign w_y  = r_ir[2:0];

    // Low DIN bits carry no instruction fields; Gnz is only consulted with mvnz.
    assign w_unused = ^{Gnz, DIN[N-10:0]};

    // Step sequencer and instruction register; IR captured on the T0 -> T1 transition.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                T0: begin
                    if (Run) begin
                        r_ir    <= DIN[N-1:N-9];
                        r_state <= T1;
                    end
                end
                T1: begin
                    if (w_op == OP_ADD || w_op == OP_SUB) begin
                        r_state <= T2;
                    end else begin
                        r_state <= T0;
                    end
                end
                T2:      r_state <= T3;
                default: r_state <= T0;
            endcase
        end
    end

    // Per-step control decode; everything held at zero while Reset is high.
    always_comb begin
        selectR   = 8'd0;
        selectG   = 1'b0;
        selectDin = 1'b0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        AddSub    = 1'b0;
        IRin      = 1'b0;
        Done      = 1'b0;
        w_rin_en  = 1'b0;
        if (!Reset) begin
            case (r_state)
                T0: IRin = Run;
                T1: begin
                    case (w_op)
                        OP_MV: begin
                            selectR  = {5'd0, w_y};
                            w_rin_en = 1'b1;
                            Done     = 1'b1;
                        end
                        OP_MVI: begin
                            selectDin = 1'b1;
                            w_rin_en  = 1'b1;
                            Done      = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            selectR = {5'd0, w_x};
                            Ain     = 1'b1;
                        end
`ifdef CTRL_MVNZ_EN
                        OP_MVNZ: begin
                            selectR  = {5'd0, w_y};
                            w_rin_en = Gnz;
                            Done     = 1'b1;
                        end
`endif
                        default: Done = 1'b1;
                    endcase
                end
                T2: begin
                    selectR = {5'd0, w_y};
                    Gin     = 1'b1;
                    AddSub  = w_op[0];
                end
                default: begin
                    selectG  = 1'b1;
                    w_rin_en = 1'b1;
                    Done     = 1'b1;
                end
            endcase
        end
    end

    dec3to8 u_dec_rin (
        .i_sel    (w_x),
        .i_en     (w_rin_en),
        .o_onehot (Rin)
    );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instruction cases then random traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Run   = 1'b0;
    logic [15:0] DIN   = 16'd0;
    logic        Gnz   = 1'b0;
    logic [7:0]  selectR;
    logic        selectG;
    logic        selectDin;
    logic [7:0]  Rin;
    logic        Ain;
    logic        Gin;
    logic        AddSub;
    logic        IRin;
    logic        Done;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: instruction being executed and the remaining step numbers.
    logic [8:0] m_ir = 9'd0;
    int         m_steps[$];

    control_unit #(.N(16)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Run       (Run),
        .DIN       (DIN),
        .Gnz       (Gnz),
        .selectR   (selectR),
        .selectG   (selectG),
        .selectDin (selectDin),
        .Rin       (Rin),
        .Ain       (Ain),
        .Gin       (Gin),
        .AddSub    (AddSub),
        .IRin      (IRin),
        .Done      (Done)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Output vector layout: {selectR, selectG, selectDin, Rin, Ain, Gin, AddSub, IRin, Done}
    function automatic logic [22:0] pack(input logic [7:0] sr, input logic sg, input logic sd,
                                         input logic [7:0] rin, input logic a, input logic g,
                                         input logic as, input logic ir, input logic dn);
        return {sr, sg, sd, rin, a, g, as, ir, dn};
    endfunction

    function automatic logic [22:0] observed();
        return pack(selectR, selectG, selectDin, Rin, Ain, Gin, AddSub, IRin, Done);
    endfunction

    // Expected outputs for step s of instruction ir (s = 0 means idle in T0).
    function automatic logic [22:0] expected(input logic rst, input logic run, input logic gnz,
                                             input logic [8:0] ir, input int s);
        int op = int'(ir[8:6]);
        int x  = int'(ir[5:3]);
        int y  = int'(ir[2:0]);
        logic [7:0] wr = 8'd1 << x;
        if (rst) return 23'd0;
        if (s == 0) return pack(0, 0, 0, 0, 0, 0, 0, run, 0);
        if (s == 2) return pack(8'(y), 0, 0, 0, 0, 1, ir[6], 0, 0);
        if (s == 3) return pack(0, 1, 0, wr, 0, 0, 0, 0, 1);
        case (op)
            0: return pack(8'(y), 0, 0, wr, 0, 0, 0, 0, 1);
            1: return pack(0, 0, 1, wr, 0, 0, 0, 0, 1);
            2, 3: return pack(8'(x), 0, 0, 0, 1, 0, 0, 0, 0);
`ifdef CTRL_MVNZ_EN
            4: return pack(8'(y), 0, 0, gnz ? wr : 8'd0, 0, 0, 0, 0, 1);
`endif
            default: return pack(0, 0, 0, 0, 0, 0, 0, 0, 1);
        endcase
    endfunction

    // Drive one cycle's inputs, then compare at the falling edge.
    task automatic step(input string tag, input logic rst, input logic run,
                        input logic [15:0] din, input logic gnz);
        int s;
        Reset = rst; Run = run; DIN = din; Gnz = gnz;
        @(negedge Clock);
        s = (m_steps.size() == 0) ? 0 : m_steps[0];
        chk(tag, 32'(observed()), 32'(expected(rst, run, gnz, m_ir, s)));
    endtask

    // Advance the model across the rising edge, then move to just past it.
    task automatic tick();
        if (Reset) begin
            m_steps.delete();
            m_ir = 9'd0;
        end else if (m_steps.size() != 0) begin
            void'(m_steps.pop_front());
        end else if (Run) begin
            m_ir = DIN[15:7];
            m_steps.push_back(1);
            if (DIN[15:13] == 3'b010 || DIN[15:13] == 3'b011) begin
                m_steps.push_back(2);
                m_steps.push_back(3);
            end
        end
        @(posedge Clock);
        #1;
    endtask

    initial begin
        @(posedge Clock);
        #1;
        // Reset, then idle with Run low: everything zero including Done.
        step("reset", 1, 0, 16'h0000, 0); chk("reset_done", 32'(Done), 32'd0); tick();
        step("idle", 0, 0, 16'h0000, 0); chk("idle_irin", 32'(IRin), 32'd0); tick();

        // mvi R2, #0xAB
        step("mvi_t0", 0, 1, 16'h2800, 0); chk("mvi_irin", 32'(IRin), 32'd1); tick();
        step("mvi_t1", 0, 0, 16'h00AB, 0);
        chk("mvi_rin", 32'(Rin), 32'h04);
        chk("mvi_seldin", 32'({selectDin, Done}), 32'b11); tick();

        // mv R1,R2, then T0 on the following cycle
        step("mv_t0", 0, 1, 16'h0500, 0); tick();
        step("mv_t1", 0, 0, 16'h0000, 0);
        chk("mv_selr", 32'(selectR), 32'd2);
        chk("mv_rin", 32'(Rin), 32'h02); tick();
        step("mv_back_t0", 0, 0, 16'h0000, 0); tick();

        // sub R5,R6 with Run held high throughout (ignored mid-instruction)
        step("sub_t0", 0, 1, 16'h7700, 0); tick();
        step("sub_t1", 0, 1, 16'hFFFF, 0); chk("sub_t1_selr", 32'(selectR), 32'd5); tick();
        step("sub_t2", 0, 1, 16'hFFFF, 0); chk("sub_t2_addsub", 32'({Gin, AddSub}), 32'b11); tick();
        step("sub_t3", 0, 1, 16'hFFFF, 0); chk("sub_t3_rin", 32'(Rin), 32'h20); tick();
        step("sub_next", 0, 0, 16'h0000, 0); tick();

        // mv R3,R3 is legal
        step("mv33_t0", 0, 1, 16'h0D80, 0); tick();
        step("mv33_t1", 0, 0, 16'h0000, 0); chk("mv33_rin", 32'(Rin), 32'h08); tick();

        // Reset during T2 of add R0,R1
        step("add_t0", 0, 1, 16'h4080, 0); tick();
        step("add_t1", 0, 0, 16'h0000, 0); tick();
        step("add_t2_rst", 1, 0, 16'h0000, 0); chk("rst_mid_gin", 32'(Gin), 32'd0); tick();
        step("after_rst", 0, 0, 16'h0000, 0); chk("after_rst_irin", 32'(IRin), 32'd0); tick();

        // Undefined opcode 111
        step("op7_t0", 0, 1, 16'hE000, 0); tick();
        step("op7_t1", 0, 0, 16'h0000, 1);
        chk("op7_done", 32'({Done, Rin, Ain, Gin}), 32'({1'b1, 8'd0, 1'b0, 1'b0})); tick();

        // Opcode 100 with Gnz low and high
        step("mvnz0_t0", 0, 1, 16'h8080, 0); tick();
        step("mvnz0_t1", 0, 0, 16'h0000, 0); chk("mvnz0_rin", 32'(Rin), 32'h00); tick();
        step("mvnz1_t0", 0, 1, 16'h8080, 1); tick();
        step("mvnz1_t1", 0, 0, 16'h0000, 1);
`ifdef CTRL_MVNZ_EN
        chk("mvnz1_rin", 32'(Rin), 32'h01);
`else
        chk("mvnz1_rin", 32'(Rin), 32'h00);
`endif
        tick();

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                 16'($urandom), $urandom_range(0, 1));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
